mem_port_arbiter: RTL and testbench

//   Shares the CPU's single memory port between instruction fetch (I) and load/store (D).

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory port signals for mem_port_arbiter.
// master: the arbiter's view; slave: the core/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  m_req;
  logic                  m_we;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W/8-1:0]   m_be;
  logic                  m_gnt;
  logic                  m_rvalid;
  logic [DATA_W-1:0]     m_rdata;

  modport master (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_be,
    input  m_gnt, m_rvalid, m_rdata
  );

  modport slave (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_be,
    output m_gnt, m_rvalid, m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding I/D memory port arbiter, D priority with starvation cap.
// Optional MEM_ARB_STATS_EN adds grant/stall counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.master bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_i_cnt,
  output logic [31:0] stat_d_cnt,
  output logic [31:0] stat_stall_cnt
`endif
);
  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e              state_q, state_d;
  logic                own_q, own_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [BE_W-1:0]     m_be_q, m_be_d;
  logic [SW-1:0]       starve_q, starve_d;

  logic pick_d;
  logic gnt_i, gnt_d, rv_i, rv_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      own_q     <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_be_q    <= m_be_d;
      starve_q  <= starve_d;
    end
  end

  // own: 1 = D port owns the transaction, 0 = I port
  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_be_d    = m_be_q;
    starve_d  = starve_q;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    rv_i      = 1'b0;
    rv_d      = 1'b0;
    pick_d    = bus.d_req &&
                (!bus.i_req || starve_q < SMAX);
    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          own_d     = 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = bus.d_we;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          m_be_d    = bus.d_be;
          state_d   = REQ;
          if (!bus.i_req)
            starve_d = '0;
          else if (starve_q != SMAX)
            starve_d = starve_q + SW'(1);
        end else if (bus.i_req) begin
          own_d     = 1'b0;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = bus.i_addr;
          m_wdata_d = '0;
          m_be_d    = '0;
          starve_d  = '0;
          state_d   = REQ;
        end else begin
          starve_d  = '0;
        end
      end
      REQ: begin
        if (bus.m_gnt) begin
          gnt_i   = !own_q;
          gnt_d   = own_q;
          m_req_d = 1'b0;
          // a store is complete once memory accepts it
          state_d = (own_q && m_we_q) ? IDLE : RESP;
        end
      end
      RESP: begin
        if (bus.m_rvalid) begin
          rv_i    = !own_q;
          rv_d    = own_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // pulses masked during reset so a dropped transaction never completes
  assign bus.i_gnt    = gnt_i & rst;
  assign bus.d_gnt    = gnt_d & rst;
  assign bus.i_rvalid = rv_i & rst;
  assign bus.d_rvalid = rv_d & rst;
  assign bus.i_rdata  = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;
  assign bus.m_req    = m_req_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.m_be     = m_be_q;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] si_q, sd_q, ss_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      si_q <= '0;
      sd_q <= '0;
      ss_q <= '0;
    end else begin
      if (gnt_i)
        si_q <= si_q + 32'd1;
      if (gnt_d)
        sd_q <= sd_q + 32'd1;
      if (state_q == REQ && !bus.m_gnt)
        ss_q <= ss_q + 32'd1;
    end
  end

  assign stat_i_cnt     = si_q;
  assign stat_d_cnt     = sd_q;
  assign stat_stall_cnt = ss_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus
// starvation, delayed-store and mid-response reset sequences.
module tb_mem_port_arbiter;
  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_i, stat_d, stat_s;
`endif

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_i_cnt(stat_i),
    .stat_d_cnt(stat_d),
    .stat_stall_cnt(stat_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic        m_gnt;
    logic        m_rv;
    logic [31:0] m_rdata;
    logic        e_mreq;
    logic [31:0] e_maddr;
    logic        e_ig;
    logic        e_dg;
    logic        e_irv;
    logic        e_drv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic ir, logic [31:0] ia, logic dr, logic dw,
    logic [31:0] da, logic mg, logic mv, logic [31:0] md,
    logic er, logic [31:0] ea, logic eig, logic edg,
    logic eirv, logic edrv);
    vec_t v;
    v.i_req = ir;  v.i_addr = ia;
    v.d_req = dr;  v.d_we = dw;  v.d_addr = da;
    v.m_gnt = mg;  v.m_rv = mv;  v.m_rdata = md;
    v.e_mreq = er; v.e_maddr = ea;
    v.e_ig = eig;  v.e_dg = edg;
    v.e_irv = eirv; v.e_drv = edrv;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.i_req    = 1'b0;
    bus.i_addr   = '0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.d_be     = '0;
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_rdata  = '0;
  endtask

  bit exp_d [10];
  int ng;
  int cyc;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] si0, sd0, ss0;
`endif

  initial begin
    idle_in();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    @(negedge clk);
    chk("rst_mreq",  bus.m_req, 0);
    chk("rst_maddr", bus.m_addr, 0);
    chk("rst_mwe",   bus.m_we, 0);
    chk("rst_mwdata", bus.m_wdata, 0);
    chk("rst_mbe",   bus.m_be, 0);
    chk("rst_gnt",   {bus.i_gnt, bus.d_gnt}, 0);
    step();
    rst = 1'b1;

    // fetch timing, then D-before-I with simultaneous requests
    tbl.push_back(mk(1,0,0,0,0,     1,0,0,           0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,     1,0,0,           1,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     1,0,0,           0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     1,1,32'h00500093,0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,     0,1,32'hBAD0BAD0,0,0,0,0,0,0));
    tbl.push_back(mk(1,4,1,0,32'h100,1,0,0,          0,0,0,0,0,0));
    tbl.push_back(mk(1,4,1,0,32'h100,1,1,32'h1,      1,32'h100,0,1,0,0));
    tbl.push_back(mk(1,4,0,0,0,     1,0,0,           0,32'h100,0,0,0,0));
    tbl.push_back(mk(1,4,0,0,0,     1,1,32'h11223344,0,32'h100,0,0,0,1));
    tbl.push_back(mk(1,4,0,0,0,     1,0,0,           0,32'h100,0,0,0,0));
    tbl.push_back(mk(1,4,0,0,0,     1,0,0,           1,32'h4,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     1,1,32'hCAFE0001,0,32'h4,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,     0,0,0,           0,32'h4,0,0,0,0));

    foreach (tbl[i]) begin
      bus.i_req    = tbl[i].i_req;
      bus.i_addr   = tbl[i].i_addr;
      bus.d_req    = tbl[i].d_req;
      bus.d_we     = tbl[i].d_we;
      bus.d_addr   = tbl[i].d_addr;
      bus.m_gnt    = tbl[i].m_gnt;
      bus.m_rvalid = tbl[i].m_rv;
      bus.m_rdata  = tbl[i].m_rdata;
      @(negedge clk);
      chk($sformatf("v%0d_mreq", i), bus.m_req, tbl[i].e_mreq);
      chk($sformatf("v%0d_maddr", i), bus.m_addr, tbl[i].e_maddr);
      chk($sformatf("v%0d_ignt", i), bus.i_gnt, tbl[i].e_ig);
      chk($sformatf("v%0d_dgnt", i), bus.d_gnt, tbl[i].e_dg);
      chk($sformatf("v%0d_irv", i), bus.i_rvalid, tbl[i].e_irv);
      chk($sformatf("v%0d_drv", i), bus.d_rvalid, tbl[i].e_drv);
      chk($sformatf("v%0d_rdata", i), bus.d_rdata, tbl[i].m_rdata);
      step();
    end

    // starvation cap: D continuously, I continuously
    exp_d = '{1,1,1,1,0,1,1,1,1,0};
`ifdef MEM_ARB_STATS_EN
    si0 = stat_i; sd0 = stat_d; ss0 = stat_s;
`endif
    bus.i_req = 1'b1; bus.i_addr = 32'h80;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h180;
    bus.m_gnt = 1'b1; bus.m_rvalid = 1'b1;
    bus.m_rdata = 32'h0000_0013;
    ng = 0;
    cyc = 0;
    while (ng < 10 && cyc < 200) begin
      @(negedge clk);
      if (bus.i_gnt || bus.d_gnt) begin
        chk($sformatf("starve_order%0d", ng), bus.d_gnt, exp_d[ng]);
        chk("gnt_overlap", bus.i_gnt & bus.d_gnt, 0);
        ng++;
      end
      step();
      cyc++;
    end
    chk("starve_grants", ng, 10);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    step();
    bus.m_rvalid = 1'b0;
    step();
`ifdef MEM_ARB_STATS_EN
    chk("stat_d", stat_d - sd0, 8);
    chk("stat_i", stat_i - si0, 2);
    chk("stat_stall", stat_s - ss0, 0);
    ss0 = stat_s;
`endif

    // store held through 3 cycles of m_gnt=0
    idle_in();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200;
    bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'hF;
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("st_mreq", bus.m_req, 1);
      chk("st_mwe", bus.m_we, 1);
      chk("st_maddr", bus.m_addr, 32'h200);
      chk("st_mwdata", bus.m_wdata, 32'hDEADBEEF);
      chk("st_mbe", bus.m_be, 4'hF);
      chk("st_early_gnt", bus.d_gnt, 0);
      step();
    end
    bus.m_gnt = 1'b1;
    @(negedge clk);
    chk("st_dgnt", bus.d_gnt, 1);
    chk("st_ignt", bus.i_gnt, 0);
    step();
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h5A5A5A5A;
    bus.i_req = 1'b1; bus.i_addr = 32'h44;
    @(negedge clk);
    chk("st_no_drv", bus.d_rvalid, 0);
    chk("st_mreq_low", bus.m_req, 0);
    chk("st_dgnt_once", bus.d_gnt, 0);
    step();
    @(negedge clk);
    chk("st_idle_mreq", bus.m_req, 1);
    chk("st_idle_maddr", bus.m_addr, 32'h44);
    chk("st_idle_ignt", bus.i_gnt, 1);
    step();
    bus.i_req = 1'b0;
    @(negedge clk);
    chk("st_fetch_irv", bus.i_rvalid, 1);
    step();
    bus.m_rvalid = 1'b0;
`ifdef MEM_ARB_STATS_EN
    chk("stat_stall3", stat_s - ss0, 3);
`endif

    // reset while a fetch waits in RESP
    bus.i_req = 1'b1; bus.i_addr = 32'h48; bus.m_gnt = 1'b1;
    step();
    @(negedge clk);
    chk("rr_ignt", bus.i_gnt, 1);
    step();
    bus.i_req = 1'b0;
    rst = 1'b0;
    bus.m_rvalid = 1'b1;
    @(negedge clk);
    chk("rr_irv_in_rst", bus.i_rvalid, 0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rr_irv_stray", bus.i_rvalid, 0);
    chk("rr_drv_stray", bus.d_rvalid, 0);
    chk("rr_mreq", bus.m_req, 0);
    chk("rr_maddr", bus.m_addr, 0);
    chk("rr_mwe", bus.m_we, 0);
    step();
    bus.m_rvalid = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
    step();
    @(negedge clk);
    chk("rr_next_mreq", bus.m_req, 1);
    chk("rr_next_maddr", bus.m_addr, 32'h300);
    chk("rr_next_dgnt", bus.d_gnt, 1);
    step();
    bus.d_req = 1'b0;
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h77;
    @(negedge clk);
    chk("rr_next_drv", bus.d_rvalid, 1);
    chk("rr_next_rdata", bus.d_rdata, 32'h77);
    step();
    bus.m_rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
